// File: rtl/mem_io_bridge_if.sv
// Data-side bus between the core's MEM stage (master) and mem_io_bridge (slave).
// Store strobe, byte address and store data go downstream; load data returns in the same cycle.
interface mem_io_bridge_if;
    logic        mem_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output mem_we, output addr, output wdata, input rdata);
    modport slave  (input mem_we, input addr, input wdata, output rdata);
endinterface

// File: rtl/mem_io_bridge.sv
// Data RAM plus memory-mapped I/O page (GPIO and down-counting timer) behind the core's MEM stage.
// Optional macro MMIO_PRESCALE_EN adds TIMER_PRESCALE at offset 0x18 and a tick prescaler.
module mem_io_bridge #(
    parameter int          DM_AW   = 10,
    parameter logic [31:0] IO_BASE = 32'h0000_7F00,
    parameter int          GPIO_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_io_bridge_if.slave    bus,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam logic [7:0] OFF_GPIO_OUT  = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN   = 8'h04;
    localparam logic [7:0] OFF_CTRL      = 8'h08;
    localparam logic [7:0] OFF_LOAD      = 8'h0C;
    localparam logic [7:0] OFF_COUNT     = 8'h10;
    localparam logic [7:0] OFF_STATUS    = 8'h14;
    localparam logic [7:0] OFF_PRESCALE  = 8'h18;

    logic             ram_hit, io_hit;
    logic [7:0]       offset;
    logic [DM_AW-1:0] word_idx;
    logic             io_we;
    logic             wr_gpio, wr_ctrl, wr_load, wr_status;
    logic             unused_addr_lsb;

    assign ram_hit   = (bus.addr[31:DM_AW+2] == '0);
    assign io_hit    = (bus.addr[31:8] == IO_BASE[31:8]);
    assign offset    = bus.addr[7:0];
    assign word_idx  = bus.addr[DM_AW+1:2];
    assign io_we     = bus.mem_we & io_hit;
    assign wr_gpio   = io_we && (offset == OFF_GPIO_OUT);
    assign wr_ctrl   = io_we && (offset == OFF_CTRL);
    assign wr_load   = io_we && (offset == OFF_LOAD);
    assign wr_status = io_we && (offset == OFF_STATUS);
    assign unused_addr_lsb = ^bus.addr[1:0];

    logic [31:0] ram [2**DM_AW];

    // NOTE: the RAM array has no reset branch on purpose; a reset loop over every word would
    // stop it mapping onto block RAM, and software must not rely on RAM contents after reset.
    always_ff @(posedge clk) begin
        if (bus.mem_we && ram_hit) ram[word_idx] <= bus.wdata;
    end

    logic [GPIO_W-1:0] sync1, sync2;
    logic              ctrl_en, ctrl_auto, ctrl_irq_en;
    logic [31:0]       load, count;
    logic              expired;
    logic              tick, expire;

`ifdef MMIO_PRESCALE_EN
    logic [7:0] prescale, pre_cnt;

    assign tick = (pre_cnt == prescale);

    // Prescaler restarts on any reprogramming so the first tick is a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            if (io_we && (offset == OFF_PRESCALE)) prescale <= bus.wdata[7:0];
            if (wr_ctrl || wr_load || !ctrl_en) pre_cnt <= '0;
            else if (tick)                      pre_cnt <= '0;
            else                                pre_cnt <= pre_cnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign expire    = ctrl_en && tick && (count == '0);
    assign timer_irq = expired & ctrl_irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out    <= '0;
            sync1       <= '0;
            sync2       <= '0;
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            load        <= '0;
            count       <= '0;
            expired     <= 1'b0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (wr_gpio) gpio_out <= bus.wdata[GPIO_W-1:0];

            // A CTRL write overrides the one-shot self-clear of EN on the same edge.
            if (wr_ctrl) begin
                ctrl_en     <= bus.wdata[0];
                ctrl_auto   <= bus.wdata[1];
                ctrl_irq_en <= bus.wdata[2];
            end else if (expire && !ctrl_auto) begin
                ctrl_en <= 1'b0;
            end

            if (wr_load) begin
                load  <= bus.wdata;
                count <= bus.wdata;
            end else if (ctrl_en && tick) begin
                if (count == '0) count <= ctrl_auto ? load : '0;
                else             count <= count - 32'd1;
            end

            if (expire)                        expired <= 1'b1;
            else if (wr_status && bus.wdata[0]) expired <= 1'b0;
        end
    end

    // NOTE: rdata gets a default before the decode so no path through the case infers a latch.
    always_comb begin
        bus.rdata = '0;
        if (ram_hit) begin
            bus.rdata = ram[word_idx];
        end else if (io_hit) begin
            case (offset)
                OFF_GPIO_OUT: bus.rdata = 32'(gpio_out);
                OFF_GPIO_IN:  bus.rdata = 32'(sync2);
                OFF_CTRL:     bus.rdata = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
                OFF_LOAD:     bus.rdata = load;
                OFF_COUNT:    bus.rdata = count;
                OFF_STATUS:   bus.rdata = {31'd0, expired};
`ifdef MMIO_PRESCALE_EN
                OFF_PRESCALE: bus.rdata = {24'd0, prescale};
`endif
                default:      bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: expectations are queued when stimulus is driven and
// popped when the combinational outputs are sampled mid-cycle (on the falling edge).
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        timer_irq;
    int          errors = 0;
    int          checks = 0;

    mem_io_bridge_if bus ();

    mem_io_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

`ifdef MMIO_PRESCALE_EN
    localparam logic [31:0] PS_READ = 32'h0000_0055;
`else
    localparam logic [31:0] PS_READ = 32'h0000_0000;
`endif

    task automatic push_exp(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Write lands on the next rising edge; returns on the following falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_we = 1'b1;
        bus.addr   = a;
        bus.wdata  = d;
        @(negedge clk);
        bus.mem_we = 1'b0;
    endtask

    task automatic check_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.mem_we = 1'b0;
        bus.addr   = a;
        push_exp(tag, exp);
        #1;
        compare(bus.rdata);
    endtask

    task automatic check_gpio(input logic [15:0] exp, input string tag);
        push_exp(tag, 32'(exp));
        #1;
        compare(32'(gpio_out));
    endtask

    task automatic check_irq(input logic exp, input string tag);
        push_exp(tag, 32'(exp));
        #1;
        compare(32'(timer_irq));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        gpio_in    = '0;
        bus.mem_we = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        step();
        step();
        rst = 1'b0;

        check_gpio(16'h0000, "reset_gpio_out");
        check_irq(1'b0, "reset_irq");
        check_rd(32'h7F08, 32'h0, "reset_ctrl");
        check_rd(32'h7F10, 32'h0, "reset_count");
        step();

        // RAM: word access, byte offset ignored, out-of-range reads 0
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        check_rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_raw");
        check_rd(32'h0000_0012, 32'hDEAD_BEEF, "ram_byte_offset");
        check_rd(32'h0001_0000, 32'h0, "ram_miss");
        step();

        // GPIO out and the two-flop input synchronizer
        wr(32'h7F00, 32'hFFFF_A5A5);
        check_gpio(16'hA5A5, "gpio_out");
        check_rd(32'h7F00, 32'h0000_A5A5, "gpio_out_read");
        gpio_in = 16'h1234;
        check_rd(32'h7F04, 32'h0, "gpio_in_before");
        step();
        check_rd(32'h7F04, 32'h0, "gpio_in_edge1");
        step();
        check_rd(32'h7F04, 32'h0000_1234, "gpio_in_edge2");
        step();

        // One-shot: LOAD=3, CTRL=EN|IRQ_EN
        wr(32'h7F0C, 32'd3);
        wr(32'h7F08, 32'h5);
        check_rd(32'h7F10, 32'd3, "os_count3");
        step();
        check_rd(32'h7F10, 32'd2, "os_count2");
        step();
        check_rd(32'h7F10, 32'd1, "os_count1");
        step();
        check_rd(32'h7F10, 32'd0, "os_count0");
        check_irq(1'b0, "os_irq_before");
        step();
        check_rd(32'h7F14, 32'h1, "os_expired");
        check_rd(32'h7F08, 32'h4, "os_en_cleared");
        check_rd(32'h7F10, 32'd0, "os_count_hold");
        check_irq(1'b1, "os_irq");
        wr(32'h7F14, 32'h1);
        check_irq(1'b0, "os_irq_cleared");
        check_rd(32'h7F14, 32'h0, "os_status_cleared");
        step();

        // Auto-reload: LOAD=2, CTRL=EN|AUTO -> period of 3
        wr(32'h7F0C, 32'd2);
        wr(32'h7F08, 32'h3);
        check_rd(32'h7F10, 32'd2, "ar_count2");
        step();
        check_rd(32'h7F10, 32'd1, "ar_count1");
        step();
        check_rd(32'h7F14, 32'h0, "ar_not_yet");
        step();
        check_rd(32'h7F14, 32'h1, "ar_expired");
        check_rd(32'h7F10, 32'd2, "ar_reloaded");
        check_irq(1'b0, "ar_irq_masked");
        wr(32'h7F14, 32'h1);
        check_rd(32'h7F14, 32'h0, "ar_cleared");
        check_rd(32'h7F10, 32'd1, "ar_count_after_clear");
        step();
        wr(32'h7F14, 32'h1);
        check_rd(32'h7F14, 32'h1, "ar_set_beats_clear");
        check_rd(32'h7F10, 32'd2, "ar_reload2");
        step();

        // Unlisted offsets and unmapped addresses
        wr(32'h7F08, 32'h0);
        wr(32'h7F1C, 32'hFFFF_FFFF);
        check_rd(32'h7F1C, 32'h0, "io_unlisted");
        wr(32'h7F18, 32'h0000_0055);
        check_rd(32'h7F18, PS_READ, "io_prescale_slot");
        wr(32'h0002_0000, 32'h11);
        check_rd(32'h0002_0000, 32'h0, "unmapped");
        step();

        // Asynchronous reset mid-count; RAM keeps its data
        wr(32'h0000_0040, 32'h1234_5678);
        wr(32'h7F0C, 32'd5);
        wr(32'h7F08, 32'h1);
        check_rd(32'h7F10, 32'd5, "rst_pre_count");
        check_rd(32'h7F14, 32'h1, "rst_pre_expired");
        rst = 1'b1;
        check_gpio(16'h0000, "rst_gpio_out");
        check_rd(32'h7F08, 32'h0, "rst_ctrl");
        check_rd(32'h7F10, 32'h0, "rst_count");
        check_rd(32'h7F14, 32'h0, "rst_expired");
        step();
        rst = 1'b0;
        check_rd(32'h0000_0040, 32'h1234_5678, "ram_survives_rst");
        check_rd(32'h7F18, 32'h0, "rst_prescale");
        step();

`ifdef MMIO_PRESCALE_EN
        // PRESCALE=3, LOAD=1, CTRL=EN -> tick every 4 clocks, expiry 8 clocks after enable
        wr(32'h7F18, 32'd3);
        wr(32'h7F0C, 32'd1);
        wr(32'h7F08, 32'h1);
        check_rd(32'h7F10, 32'd1, "ps_count_start");
        repeat (3) step();
        check_rd(32'h7F10, 32'd1, "ps_count_held");
        step();
        check_rd(32'h7F10, 32'd0, "ps_count_tick");
        check_rd(32'h7F14, 32'h0, "ps_not_expired");
        repeat (3) step();
        check_rd(32'h7F14, 32'h0, "ps_not_expired7");
        step();
        check_rd(32'h7F14, 32'h1, "ps_expired8");
        check_rd(32'h7F08, 32'h0, "ps_en_cleared");
        step();
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: observed=%0d leftover expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
